// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
//   Streaming 3x3 neighbourhood generator for raster-order RGB444 pixels.
//   Two line buffers feed the top/middle rows of a 3x3 register window; the
//   incoming pixel forms the bottom row. After the last pixel of a frame the
//   block injects IMG_WIDTH+1 zero pixels so every input pixel receives exactly
//   one window (in raster order of its center).
//
//   Build option: define WINDOW_GEN_REPLICATE_BORDER_EN to replace zero padding
//   at the image border with nearest-edge replication. Timing is identical.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   pixel_in      incoming pixel, R[11:8] G[7:4] B[3:0]
//   pixel_valid   pixel_in valid this cycle
//   frame_start   marks pixel (0,0) of a frame (qualified by pixel_valid)
//   in_ready      pixel accepted when pixel_valid & in_ready
//   color_data    center,left,right,up,down,upleft,upright,downleft,downright
//   window_valid  color_data valid this cycle
//   window_x/y    center coordinate of the current window
//   frame_done    pulse with the last window of a frame
// -----------------------------------------------------------------------------
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int PIX_W      = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PIX_W-1:0]     pixel_in,
    input  logic                 pixel_valid,
    input  logic                 frame_start,
    output logic                 in_ready,
    output logic [9*PIX_W-1:0]   color_data,
    output logic                 window_valid,
    output logic [8:0]           window_x,
    output logic [7:0]           window_y,
    output logic                 frame_done
);

    localparam int XI = $clog2(IMG_WIDTH);
    localparam int YI = $clog2(IMG_HEIGHT);
    localparam int FI = $clog2(IMG_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [XI-1:0]            in_x_q, in_x_d;
    logic [YI-1:0]            in_y_q, in_y_d;
    logic [FI-1:0]            fl_cnt_q, fl_cnt_d;
    logic [XI-1:0]            ox_q, ox_d;      // center of the next window
    logic [YI-1:0]            oy_q, oy_d;
    logic [8:0][PIX_W-1:0]    win_q, win_d;    // index row*3+col, row 0 = top
    logic [9*PIX_W-1:0]       color_q, color_d;
    logic                     wvalid_q, wvalid_d;
    logic [8:0]               wx_q, wx_d;
    logic [7:0]               wy_q, wy_d;
    logic                     fdone_q, fdone_d;

    logic [PIX_W-1:0]         lb0_q [IMG_WIDTH];  // previous row
    logic [PIX_W-1:0]         lb1_q [IMG_WIDTH];  // row before that

    logic                     advance, start, emit, primed, last_pix;
    logic [XI-1:0]            lb_addr;
    logic [PIX_W-1:0]         pix_new;
    logic [8:0][PIX_W-1:0]    nw;
    logic                     at_l, at_r, at_t, at_b;

    // Tap order matches the color_data packing, most significant first.
    function automatic logic [1:0] tap_r(input int k);
        case (k)
            0, 1, 2: tap_r = 2'd1;
            3, 5, 6: tap_r = 2'd0;
            default: tap_r = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] tap_c(input int k);
        case (k)
            0, 3, 4: tap_c = 2'd1;
            1, 5, 7: tap_c = 2'd0;
            default: tap_c = 2'd2;
        endcase
    endfunction

    // Window for the current center exists once a full row plus one pixel
    // beyond it has been accepted (linear index >= IMG_WIDTH+1).
    assign primed   = (in_y_q > YI'(1)) || ((in_y_q == YI'(1)) && (in_x_q != '0));
    assign last_pix = (in_x_q == XI'(IMG_WIDTH - 1)) && (in_y_q == YI'(IMG_HEIGHT - 1));

    // ---------------------------------------------------------------- control
    always_comb begin
        state_d  = state_q;
        fl_cnt_d = fl_cnt_q;
        advance  = 1'b0;
        start    = 1'b0;
        emit     = 1'b0;
        pix_new  = pixel_in;

        case (state_q)
            S_IDLE: begin
                if (pixel_valid && frame_start) begin
                    start   = 1'b1;
                    advance = 1'b1;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pixel_valid) begin
                    advance = 1'b1;
                    if (frame_start) begin
                        // Abort: pending windows are simply never emitted.
                        start = 1'b1;
                    end else begin
                        emit = primed;
                        if (last_pix) begin
                            state_d  = S_FLUSH;
                            fl_cnt_d = '0;
                        end
                    end
                end
            end
            S_FLUSH: begin
                advance  = 1'b1;
                emit     = 1'b1;
                pix_new  = '0;
                fl_cnt_d = fl_cnt_q + FI'(1);
                if (fl_cnt_q == FI'(IMG_WIDTH)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ coordinates
    always_comb begin
        in_x_d  = in_x_q;
        in_y_d  = in_y_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        lb_addr = start ? '0 : in_x_q;

        if (advance) begin
            if (start) begin
                in_x_d = XI'(1);
                in_y_d = '0;
                ox_d   = '0;
                oy_d   = '0;
            end else if (in_x_q == XI'(IMG_WIDTH - 1)) begin
                // During flush in_y may run past the frame; only in_x matters.
                in_x_d = '0;
                in_y_d = in_y_q + YI'(1);
            end else begin
                in_x_d = in_x_q + XI'(1);
            end
        end

        if (emit) begin
            if (ox_q == XI'(IMG_WIDTH - 1)) begin
                ox_d = '0;
                oy_d = (oy_q == YI'(IMG_HEIGHT - 1)) ? '0 : oy_q + YI'(1);
            end else begin
                ox_d = ox_q + XI'(1);
            end
        end
    end

    // ------------------------------------------------------- window + output
    assign at_l = (ox_q == '0);
    assign at_r = (ox_q == XI'(IMG_WIDTH - 1));
    assign at_t = (oy_q == '0);
    assign at_b = (oy_q == YI'(IMG_HEIGHT - 1));

    always_comb begin
        // Shift left by one column; the new right column is the pixel stream
        // at this x together with the two stored rows above it.
        nw = '0;
        for (int r = 0; r < 3; r++) begin
            nw[r*3 + 0] = win_q[r*3 + 1];
            nw[r*3 + 1] = win_q[r*3 + 2];
        end
        nw[2] = lb1_q[lb_addr];
        nw[5] = lb0_q[lb_addr];
        nw[8] = pix_new;
        win_d = advance ? nw : win_q;
    end

    always_comb begin
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] idx;
        logic       oob;
        color_d = color_q;
        r       = '0;
        c       = '0;
        idx     = '0;
        oob     = 1'b0;
        if (emit) begin
            for (int k = 0; k < 9; k++) begin
                r   = tap_r(k);
                c   = tap_c(k);
                // Masking is on the center coordinate, so pixels from the
                // adjacent row that wrapped into the window never leak.
                oob = ((c == 2'd0) && at_l) || ((c == 2'd2) && at_r) ||
                      ((r == 2'd0) && at_t) || ((r == 2'd2) && at_b);
`ifdef WINDOW_GEN_REPLICATE_BORDER_EN
                if (((r == 2'd0) && at_t) || ((r == 2'd2) && at_b)) r = 2'd1;
                if (((c == 2'd0) && at_l) || ((c == 2'd2) && at_r)) c = 2'd1;
                idx = {2'b00, r} * 4'd3 + {2'b00, c};
                color_d[(8-k)*PIX_W +: PIX_W] = nw[idx];
`else
                idx = {2'b00, r} * 4'd3 + {2'b00, c};
                color_d[(8-k)*PIX_W +: PIX_W] = oob ? '0 : nw[idx];
`endif
            end
        end
    end

    always_comb begin
        wvalid_d = emit;
        wx_d     = emit ? 9'(ox_q) : wx_q;
        wy_d     = emit ? 8'(oy_q) : wy_q;
        fdone_d  = emit && at_r && at_b;
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            in_x_q   <= '0;
            in_y_q   <= '0;
            fl_cnt_q <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            win_q    <= '0;
            color_q  <= '0;
            wvalid_q <= 1'b0;
            wx_q     <= '0;
            wy_q     <= '0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_x_q   <= in_x_d;
            in_y_q   <= in_y_d;
            fl_cnt_q <= fl_cnt_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            win_q    <= win_d;
            color_q  <= color_d;
            wvalid_q <= wvalid_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
            fdone_q  <= fdone_d;
        end
    end

    // Line buffer contents need no reset: border masking hides stale data.
    always_ff @(posedge clk) begin
        if (advance) begin
            lb1_q[lb_addr] <= lb0_q[lb_addr];
            lb0_q[lb_addr] <= pix_new;
        end
    end

    assign in_ready     = !reset && (state_q != S_FLUSH);
    assign color_data   = color_q;
    assign window_valid = wvalid_q;
    assign window_x     = wx_q;
    assign window_y     = wy_q;
    assign frame_done   = fdone_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_gen_3x3
//   Directed frames on a 4x3 image (pixel (x,y) = y*4+x+1) checked every cycle
//   against an image-array model that computes each window from neighbour
//   coordinates, plus literal expectations for selected windows.
// -----------------------------------------------------------------------------
module tb_window_gen_3x3;

    localparam int W = 4;
    localparam int H = 3;

    localparam logic [107:0] L11 = 108'h006_005_007_002_00A_001_003_009_00B;
`ifdef WINDOW_GEN_REPLICATE_BORDER_EN
    localparam logic [107:0] L00 = 108'h001_001_002_001_005_001_002_005_006;
    localparam logic [107:0] L32 = 108'h00C_00B_00C_008_00C_007_008_00B_00C;
`else
    localparam logic [107:0] L00 = 108'h001_000_002_000_005_000_000_000_006;
    localparam logic [107:0] L32 = 108'h00C_00B_000_008_000_007_000_000_000;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [11:0]   pixel_in = '0;
    logic          pixel_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic          in_ready;
    logic [107:0]  color_data;
    logic          window_valid;
    logic [8:0]    window_x;
    logic [7:0]    window_y;
    logic          frame_done;

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(12)) dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .in_ready(in_ready), .color_data(color_data),
        .window_valid(window_valid), .window_x(window_x), .window_y(window_y),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [107:0] got, input logic [107:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [11:0]  img [W*H];
    int           n = -1;          // accepted pixels in current frame, -1 = none
    int           wcnt = 0;        // windows emitted in current frame
    int           flush_left = 0;
    bit           pend_v = 0;
    logic [107:0] pend_d = '0;
    int           pend_x = 0, pend_y = 0;
    bit           pend_done = 0;

    function automatic logic [11:0] nb(input int x, input int y);
`ifdef WINDOW_GEN_REPLICATE_BORDER_EN
        if (x < 0) x = 0;
        if (x > W-1) x = W-1;
        if (y < 0) y = 0;
        if (y > H-1) y = H-1;
        return img[y*W + x];
`else
        if (x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
        return img[y*W + x];
`endif
    endfunction

    function automatic logic [107:0] exp_win(input int cx, input int cy);
        return {nb(cx, cy), nb(cx-1, cy), nb(cx+1, cy), nb(cx, cy-1), nb(cx, cy+1),
                nb(cx-1, cy-1), nb(cx+1, cy-1), nb(cx-1, cy+1), nb(cx+1, cy+1)};
    endfunction

    task automatic emit_win();
        pend_v    = 1;
        pend_x    = wcnt % W;
        pend_y    = wcnt / W;
        pend_d    = exp_win(pend_x, pend_y);
        pend_done = (wcnt == W*H - 1);
        wcnt++;
    endtask

    logic [107:0] got [W*H];
    int           win_total = 0;

    // Outputs seen here reflect the last rising edge; inputs seen here are what
    // the next rising edge will sample.
    always @(negedge clk) begin
        int idx;
        if (reset) begin
            n = -1; wcnt = 0; flush_left = 0; pend_v = 0;
        end else begin
            if (window_valid) begin
                win_total++;
                if (window_x < W && window_y < H)
                    got[int'(window_y)*W + int'(window_x)] = color_data;
            end
            chk("in_ready", {107'd0, in_ready}, {107'd0, flush_left == 0});
            chk("window_valid", {107'd0, window_valid}, {107'd0, pend_v});
            if (pend_v) begin
                chk("color_data", color_data, pend_d);
                chk("window_x", {99'd0, window_x}, 108'(pend_x));
                chk("window_y", {100'd0, window_y}, 108'(pend_y));
                chk("frame_done", {107'd0, frame_done}, {107'd0, pend_done});
            end else begin
                chk("frame_done_quiet", {107'd0, frame_done}, 108'd0);
            end

            pend_v = 0;
            if (flush_left > 0) begin
                emit_win();
                flush_left--;
            end else if (pixel_valid) begin
                if (frame_start) begin idx = 0; wcnt = 0; end
                else if (n >= 0) idx = n;
                else idx = -1;
                if (idx >= 0) begin
                    img[idx] = pixel_in;
                    n = idx + 1;
                    if (idx >= W + 1) emit_win();
                    if (idx == W*H - 1) begin flush_left = W + 1; n = -1; end
                end
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic idle(input int c);
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        repeat (c) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [11:0] p, input bit fs);
        int g = 0;
        pixel_in = p; frame_start = fs; pixel_valid = 1'b1;
        while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
        if (g >= 200) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed %0b for %0d cycles", in_ready, g);
        end
        @(posedge clk); #1;
        pixel_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic frame(input bit gaps);
        for (int i = 0; i < W*H; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 1));
            send(12'(i + 1), i == 0);
        end
    endtask

    task automatic lowcount(output int c);
        c = 0;
        while (!in_ready && c < 100) begin @(posedge clk); #1; c++; end
    endtask

    task automatic clear_got();
        for (int i = 0; i < W*H; i++) got[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int w0;

        // Pin the model to hand-computed windows.
        for (int i = 0; i < W*H; i++) img[i] = 12'(i + 1);
        chk("model_win00", exp_win(0, 0), L00);
        chk("model_win11", exp_win(1, 1), L11);
        chk("model_win32", exp_win(3, 2), L32);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {107'd0, in_ready}, 108'd0);
        chk("rst_valid", {107'd0, window_valid}, 108'd0);
        chk("rst_color", color_data, 108'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {107'd0, in_ready}, 108'd1);
        idle(2);

        // Basic back-to-back frame.
        clear_got(); w0 = win_total;
        frame(0);
        lowcount(c);
        chk("flush_low_cycles", 108'(c), 108'(W + 1));
        idle(3);
        chk("basic_count", 108'(win_total - w0), 108'(W*H));
        chk("basic_win00", got[0], L00);
        chk("basic_win11", got[5], L11);
        chk("basic_win32", got[11], L32);

        // Same frame with random input gaps.
        clear_got(); w0 = win_total;
        frame(1);
        lowcount(c);
        idle(3);
        chk("gap_count", 108'(win_total - w0), 108'(W*H));
        chk("gap_win00", got[0], L00);
        chk("gap_win11", got[5], L11);
        chk("gap_win32", got[11], L32);

        // Pixels without frame_start in IDLE are dropped.
        w0 = win_total;
        for (int i = 0; i < 5; i++) send(12'(i + 1), 1'b0);
        idle(3);
        chk("drop_count", 108'(win_total - w0), 108'd0);

        // Abort after 7 pixels, then a full frame.
        clear_got(); w0 = win_total;
        for (int i = 0; i < 7; i++) send(12'(i + 1), i == 0);
        frame(0);
        lowcount(c);
        idle(3);
        chk("abort_count", 108'(win_total - w0), 108'(2 + W*H));
        chk("abort_win00", got[0], L00);
        chk("abort_win32", got[11], L32);

        // Reset pulse in the middle of the flush.
        frame(0);
        idle(2);
        reset = 1'b1;
        #1;
        chk("flushrst_valid", {107'd0, window_valid}, 108'd0);
        chk("flushrst_color", color_data, 108'd0);
        chk("flushrst_x", {99'd0, window_x}, 108'd0);
        chk("flushrst_y", {100'd0, window_y}, 108'd0);
        chk("flushrst_done", {107'd0, frame_done}, 108'd0);
        chk("flushrst_ready", {107'd0, in_ready}, 108'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("flushrst_ready_rel", {107'd0, in_ready}, 108'd1);
        clear_got(); w0 = win_total;
        frame(0);
        lowcount(c);
        idle(3);
        chk("postrst_count", 108'(win_total - w0), 108'(W*H));
        chk("postrst_win00", got[0], L00);
        chk("postrst_win11", got[5], L11);

        idle(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
